aemb_fsl_slave: RTL

- FSL responder: the slave end of the core's FSL strobe/acknowledge interface (fsl_stb_o, fsl_wre_o, fsl_ack_i).
- Bridges core put/get transfers onto two buffered valid/ready streams toward a coprocessor or peripheral.
  - Put path: core to peripheral.
  - Get path: peripheral to core.
- Sits on the FSL bus next to the core; clocked on the core clock.

---
 rtl/aemb_fsl_pkg.sv | 12 +
 rtl/aemb_fsl_slave_if.sv | 36 +++
 rtl/aemb_fsl_fifo.sv | 61 ++++++
 rtl/aemb_fsl_slave.sv | 87 ++++++++
 4 files changed

// File: rtl/aemb_fsl_pkg.sv
// Shared constants and handshake state encoding for the FSL slave bridge.
package aemb_fsl_pkg;

    localparam int FSL_AW = 2;
    localparam int FSL_DW = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } fsl_state_t;

endpackage

// File: rtl/aemb_fsl_slave_if.sv
// FSL strobe/ack port plus the put (toward peripheral) and get (from peripheral) streams.
interface aemb_fsl_slave_if
    import aemb_fsl_pkg::*;
#(
    parameter int AW = FSL_AW,
    parameter int DW = FSL_DW
);

    logic          fsl_stb_i;
    logic          fsl_wre_i;
    logic [DW-1:0] fsl_dat_i;
    logic          fsl_ack_o;
    logic [DW-1:0] fsl_dat_o;

    logic [DW-1:0] m_dat_o;
    logic          m_vld_o;
    logic          m_rdy_i;

    logic [DW-1:0] s_dat_i;
    logic          s_vld_i;
    logic          s_rdy_o;

    logic [AW:0]   put_cnt_o;
    logic [AW:0]   get_cnt_o;

    modport slave (
        input  fsl_stb_i, fsl_wre_i, fsl_dat_i, m_rdy_i, s_dat_i, s_vld_i,
        output fsl_ack_o, fsl_dat_o, m_dat_o, m_vld_o, s_rdy_o, put_cnt_o, get_cnt_o
    );

    modport master (
        output fsl_stb_i, fsl_wre_i, fsl_dat_i, m_rdy_i, s_dat_i, s_vld_i,
        input  fsl_ack_o, fsl_dat_o, m_dat_o, m_vld_o, s_rdy_o, put_cnt_o, get_cnt_o
    );

endinterface

// File: rtl/aemb_fsl_fifo.sv
// Synchronous FIFO, 2**AW entries; head visible combinationally from storage.
// Push ignored when full, pop ignored when empty; simultaneous push+pop keeps count.
module aemb_fsl_fifo
    import aemb_fsl_pkg::*;
#(
    parameter int AW = FSL_AW,
    parameter int DW = FSL_DW
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge gclk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aemb_fsl_slave.sv
// FSL slave: core puts go to a FIFO toward the peripheral, core gets drain a FIFO from it.
// Ack one cycle after acceptance; a request blocks (no ack) while its FIFO is full/empty.
module aemb_fsl_slave
    import aemb_fsl_pkg::*;
#(
    parameter int AW = FSL_AW,
    parameter int DW = FSL_DW
) (
    input  logic               gclk,
    input  logic               grst,
    aemb_fsl_slave_if.slave    bus
);

    fsl_state_t    state;
    fsl_state_t    state_nxt;
    logic          req;
    logic          put_go;
    logic          get_go;
    logic [DW-1:0] dat_q;

    logic          put_full;
    logic          put_empty;
    logic          get_full;
    logic          get_empty;
    logic [DW-1:0] get_head;
    logic          m_pop;
    logic          s_push;

    // Requests are only taken in IDLE, which guarantees a gap between acks.
    always_comb begin
        state_nxt = state;
        req       = bus.fsl_stb_i & (state == ST_IDLE);
        put_go    = req & bus.fsl_wre_i & ~put_full;
        get_go    = req & ~bus.fsl_wre_i & ~get_empty;
        case (state)
            ST_IDLE: if (put_go | get_go) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state <= ST_IDLE;
            dat_q <= '0;
        end else begin
            state <= state_nxt;
            if (get_go) begin
                dat_q <= get_head;
            end
        end
    end

    assign bus.fsl_ack_o = (state == ST_ACK);
    assign bus.fsl_dat_o = dat_q;

    assign m_pop       = ~put_empty & bus.m_rdy_i;
    assign bus.m_vld_o = ~put_empty;

    assign bus.s_rdy_o = ~get_full & ~grst;
    assign s_push      = bus.s_vld_i & bus.s_rdy_o;

    aemb_fsl_fifo #(.AW(AW), .DW(DW)) u_put_fifo (
        .gclk     (gclk),
        .grst     (grst),
        .push     (put_go),
        .push_dat (bus.fsl_dat_i),
        .pop      (m_pop),
        .pop_dat  (bus.m_dat_o),
        .full     (put_full),
        .empty    (put_empty),
        .count    (bus.put_cnt_o)
    );

    aemb_fsl_fifo #(.AW(AW), .DW(DW)) u_get_fifo (
        .gclk     (gclk),
        .grst     (grst),
        .push     (s_push),
        .push_dat (bus.s_dat_i),
        .pop      (get_go),
        .pop_dat  (get_head),
        .full     (get_full),
        .empty    (get_empty),
        .count    (bus.get_cnt_o)
    );

endmodule
